// File: rtl/reg_file_pkg.sv
// Shared defaults and the write-legality rule for the 2-read/1-write register file.
package reg_file_pkg;

  localparam int RF_DATA_W_DEF = 4;
  localparam int RF_ADDR_W_DEF = 4;
  localparam int RF_DEPTH_DEF  = 16;

  // A write lands only inside the populated range, and never on a hard-wired zero entry.
  function automatic logic rf_legal_wr(input int unsigned addr, input logic zero_reg,
                                       input int unsigned depth);
    return (addr < depth) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/reg_file_rdport.sv
// One read port: range check, zero-entry rule, write bypass and optional output register.
module reg_file_rdport
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W_DEF,
  parameter int ADDR_W   = RF_ADDR_W_DEF,
  parameter int DEPTH    = RF_DEPTH_DEF,
  parameter int READ_REG = 0,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [DEPTH*DATA_W-1:0] mem,
  input  logic                    wr_legal,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [DATA_W-1:0]       rd_data
);

  logic [DATA_W-1:0] mem_word;
  logic [DATA_W-1:0] rd_comb;
  logic              in_range;
  logic              zero_hit;
  logic              bypass_hit;

  always_comb begin
    mem_word = '0;
    in_range = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        mem_word = mem[i*DATA_W +: DATA_W];
        in_range = 1'b1;
      end
    end
    zero_hit   = (ZERO_REG != 0) && (rd_addr == '0);
    bypass_hit = (BYPASS != 0) && wr_legal && (wr_addr == rd_addr);
    // The zero entry wins over a forwarded write.
    if (!in_range || zero_hit) begin
      rd_comb = '0;
    end else if (bypass_hit) begin
      rd_comb = wr_data;
    end else begin
      rd_comb = mem_word;
    end
  end

  generate
    if (READ_REG != 0) begin : g_reg
      logic [DATA_W-1:0] rd_data_q;
      logic [DATA_W-1:0] rd_data_d;

      always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
          rd_data_d = rd_comb;
        end
      end

      always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
          rd_data_q <= '0;
        end else begin
          rd_data_q <= rd_data_d;
        end
      end

      assign rd_data = rd_data_q;
    end else begin : g_comb
      logic unused_reg_ctl;
      assign unused_reg_ctl = ^{clk, clr, rd_en};
      assign rd_data        = rd_comb;
    end
  endgenerate

endmodule

// File: rtl/reg_file_2r1w.sv
// Parametrised register file: one write port, two independent read ports, per-entry valid flags.
module reg_file_2r1w
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W_DEF,
  parameter int ADDR_W   = RF_ADDR_W_DEF,
  parameter int DEPTH    = RF_DEPTH_DEF,
  parameter int READ_REG = 0,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DEPTH-1:0]  valid
);

  logic [DEPTH*DATA_W-1:0] mem_q;
  logic [DEPTH*DATA_W-1:0] mem_d;
  logic [DEPTH-1:0]        valid_q;
  logic [DEPTH-1:0]        valid_d;
  logic                    wr_legal;

  // Gating with clr keeps the bypass path quiet while the array is held in reset.
  assign wr_legal = clr && wr_en && rf_legal_wr(32'(wr_addr), (ZERO_REG != 0), DEPTH);

  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    if (wr_legal) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_addr == ADDR_W'(i)) begin
          mem_d[i*DATA_W +: DATA_W] = wr_data;
          valid_d[i]                = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      mem_q   <= '0;
      valid_q <= '0;
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
    end
  end

  assign valid = valid_q;

  reg_file_rdport #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .READ_REG(READ_REG), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
  ) u_rd_a (
    .clk     (clk),
    .clr     (clr),
    .mem     (mem_q),
    .wr_legal(wr_legal),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en_a),
    .rd_addr (rd_addr_a),
    .rd_data (rd_data_a)
  );

  reg_file_rdport #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .READ_REG(READ_REG), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
  ) u_rd_b (
    .clk     (clk),
    .clr     (clr),
    .mem     (mem_q),
    .wr_legal(wr_legal),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en_b),
    .rd_addr (rd_addr_b),
    .rd_data (rd_data_b)
  );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Four configurations of reg_file_2r1w driven in lockstep and checked against a behavioural model.
module tb_reg_file_2r1w;

  logic        clk = 1'b0;
  logic        clr;
  logic        wr_en;
  logic [3:0]  wr_addr, wr_data;
  logic        rd_en_a, rd_en_b;
  logic [3:0]  rd_addr_a, rd_addr_b;
  logic [3:0]  a0, b0, a1, b1, a2, b2, a3, b3;
  logic [15:0] v0, v1, v2;
  logic [11:0] v3;

  always #5 clk = ~clk;

  // u0: default, u1: no bypass, u2: registered read, u3: zero entry with 12 entries
  reg_file_2r1w u0 (.clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(a0),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(b0), .valid(v0));
  reg_file_2r1w #(.BYPASS(0)) u1 (.clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(a1),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(b1), .valid(v1));
  reg_file_2r1w #(.READ_REG(1)) u2 (.clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(a2),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(b2), .valid(v2));
  reg_file_2r1w #(.ZERO_REG(1), .DEPTH(12)) u3 (.clk(clk), .clr(clr), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a),
    .rd_data_a(a3), .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(b3), .valid(v3));

  int nvec  = 0;
  int nfail = 0;

  int         dep [4] = '{16, 16, 16, 12};
  bit         zr  [4] = '{0, 0, 0, 1};
  bit         bp  [4] = '{1, 0, 1, 1};
  logic [3:0] m   [4][16];
  logic [15:0] mv [4];
  logic [3:0] ra, rb;

  typedef struct {
    string      tag;
    int         k;
    int         p;
    logic [3:0] exp;
  } sb_t;
  sb_t q[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] dut_rd(input int k, input int p);
    case (k)
      0:       return (p == 0) ? a0 : b0;
      1:       return (p == 0) ? a1 : b1;
      2:       return (p == 0) ? a2 : b2;
      default: return (p == 0) ? a3 : b3;
    endcase
  endfunction

  function automatic logic [15:0] dut_valid(input int k);
    case (k)
      0:       return v0;
      1:       return v1;
      2:       return v2;
      default: return {4'h0, v3};
    endcase
  endfunction

  function automatic bit wlegal(input int k);
    return (clr === 1'b1) && (wr_en === 1'b1) && (int'(wr_addr) < dep[k]) &&
           !(zr[k] && wr_addr == 4'd0);
  endfunction

  function automatic logic [3:0] exp_rd(input int k, input logic [3:0] addr);
    if (int'(addr) >= dep[k] || (zr[k] && addr == 4'd0)) return 4'h0;
    if (bp[k] && wlegal(k) && wr_addr == addr) return wr_data;
    return m[k][addr];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 16; i++) m[k][i] = 4'h0;
      mv[k] = 16'h0;
    end
    ra = 4'h0;
    rb = 4'h0;
  endtask

  task automatic push(input string tag, input int k, input int p, input logic [3:0] exp);
    sb_t e;
    e.tag = tag;
    e.k   = k;
    e.p   = p;
    e.exp = exp;
    q.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk($sformatf("%s_u%0d_%s", e.tag, e.k, (e.p != 0) ? "b" : "a"), 16'(dut_rd(e.k, e.p)),
          16'(e.exp));
    end
  endtask

  // Inputs are already driven; check combinational ports, cross one edge, check registered port.
  task automatic step(input string tag);
    logic [3:0] na, nb;
    bit         wl[4];
    #1;
    for (int k = 0; k < 4; k++) begin
      if (k != 2) begin
        push(tag, k, 0, exp_rd(k, rd_addr_a));
        push(tag, k, 1, exp_rd(k, rd_addr_b));
      end
    end
    drain();
    na = (clr !== 1'b1) ? 4'h0 : (rd_en_a ? exp_rd(2, rd_addr_a) : ra);
    nb = (clr !== 1'b1) ? 4'h0 : (rd_en_b ? exp_rd(2, rd_addr_b) : rb);
    push(tag, 2, 0, na);
    push(tag, 2, 1, nb);
    for (int k = 0; k < 4; k++) wl[k] = wlegal(k);
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (wl[k]) begin
        m[k][wr_addr]  = wr_data;
        mv[k][wr_addr] = 1'b1;
      end
    end
    ra = na;
    rb = nb;
    #1;
    drain();
    for (int k = 0; k < 4; k++) chk($sformatf("%s_valid_u%0d", tag, k), dut_valid(k), mv[k]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b0; wr_en = 1'b0; wr_addr = 4'h0; wr_data = 4'h0;
    rd_en_a = 1'b0; rd_en_b = 1'b0; rd_addr_a = 4'h0; rd_addr_b = 4'h0;
    model_reset();
    @(posedge clk);
    #1;
    clr = 1'b1;

    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 4'hF;
      rd_en_a = 1'b1; rd_en_b = 1'b1; rd_addr_a = 4'(i); rd_addr_b = 4'(15 - i);
      step("fill_f");
    end
    chk("pre_reset_valid", v0, 16'hFFFF);

    // Reset asserted between edges must clear everything without a clock.
    wr_en = 1'b0;
    #2;
    clr = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_async_a_u%0d", k), 16'(dut_rd(k, 0)), 16'h0);
      chk($sformatf("rst_async_b_u%0d", k), 16'(dut_rd(k, 1)), 16'h0);
      chk($sformatf("rst_async_valid_u%0d", k), dut_valid(k), 16'h0);
    end
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 4'h7; rd_addr_a = 4'd2;
    step("rst_wr");
    chk("rst_wr_valid", v0, 16'h0);

    clr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 4'(i);
      rd_addr_a = 4'(i); rd_addr_b = 4'(15 - i);
      step("fill");
    end
    chk("fill_valid_u0", v0, 16'hFFFF);
    chk("fill_valid_u3", {4'h0, v3}, 16'h0FFE);

    wr_en = 1'b0; wr_data = 4'h1;
    for (int i = 0; i < 16; i++) begin
      wr_addr = 4'(i); rd_addr_a = 4'(i); rd_addr_b = 4'(15 - i);
      #1;
      chk("sweep_a", 16'(a0), 16'(i));
      chk("sweep_b", 16'(b0), 16'(15 - i));
      step("sweep");
    end
    chk("nowr_valid", v0, 16'hFFFF);

    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 4'hA; rd_addr_a = 4'd5; rd_addr_b = 4'd5;
    #1;
    chk("bypass_on_a", 16'(a0), 16'hA);
    chk("bypass_on_b", 16'(b0), 16'hA);
    chk("bypass_off_old", 16'(a1), 16'h5);
    step("bypass");
    wr_en = 1'b0;
    #1;
    chk("bypass_off_new", 16'(a1), 16'hA);
    step("bypass_after");

    rd_en_a = 1'b1; rd_addr_a = 4'd3;
    step("rreg_load");
    chk("rreg_load", 16'(a2), 16'h3);
    rd_en_a = 1'b0; rd_addr_a = 4'd7;
    step("rreg_hold");
    chk("rreg_hold", 16'(a2), 16'h3);

    rd_en_a = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 4'h9; rd_addr_a = 4'd0; rd_addr_b = 4'd0;
    #1;
    chk("zero_over_bypass", 16'(a3), 16'h0);
    chk("nonzero_bypass", 16'(a0), 16'h9);
    step("zr_w0");
    wr_addr = 4'd13; rd_addr_a = 4'd13;
    step("zr_w13");
    wr_en = 1'b0; rd_addr_a = 4'd0; rd_addr_b = 4'd13;
    #1;
    chk("zr_rd0", 16'(a3), 16'h0);
    chk("zr_rd13", 16'(b3), 16'h0);
    chk("zr_valid", {4'h0, v3}, 16'h0FFE);
    chk("nz_rd0", 16'(a0), 16'h9);
    chk("nz_rd13", 16'(b0), 16'h9);
    step("zr_rd");
    for (int i = 1; i < 12; i++) begin
      rd_addr_a = 4'(i);
      #1;
      chk("zr_keep", 16'(a3), (i == 5) ? 16'hA : 16'(i));
      step("zr_sweep");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
